// File: rtl/battle_city_pkg.sv
// rtl/battle_city_pkg.sv - shared types and constants for the battle city game logic
package battle_city_pkg;

  typedef enum logic [1:0] {
    S_HIDDEN,
    S_PICK,
    S_SPAWN,
    S_ACTIVE
  } gold_state_t;

  typedef logic [4:0] tile_t;

  localparam int TILE_SIZE = 32;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, one step per clock
module lfsr16
  import battle_city_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/gold_spawn_controller.sv
// rtl/gold_spawn_controller.sv - gold spawn/take FSM; GOLD_TIMEOUT_EN enables gold expiry
module gold_spawn_controller
  import battle_city_pkg::*;
#(
  parameter int          GRID_X_MAX      = 19,
  parameter int          GRID_Y_MAX      = 14,
  parameter int          RESPAWN_FRAMES  = 120,
  parameter int          LIFETIME_FRAMES = 600,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          MAX_TRIES       = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       frame_tick,
  input  logic       gold_take1,
  input  logic       gold_take2,
  output logic [4:0] randomX,
  output logic [4:0] randomY,
  output logic       gold_up,
  output logic       gold_active,
  output logic       p1_score,
  output logic       p2_score
);

  localparam tile_t       GX         = tile_t'(GRID_X_MAX);
  localparam tile_t       GY         = tile_t'(GRID_Y_MAX);
  localparam tile_t       FB_X       = tile_t'(GRID_X_MAX / 2);
  localparam tile_t       FB_Y       = tile_t'(GRID_Y_MAX / 2);
  localparam logic [15:0] RESPAWN_LD = 16'(RESPAWN_FRAMES);
  localparam logic [15:0] LIFE_LD    = 16'(LIFETIME_FRAMES);
  localparam logic [3:0]  LAST_TRY   = 4'(MAX_TRIES - 1);

  gold_state_t state, state_n;
  logic [15:0] frame_cnt, frame_cnt_n;
  logic [3:0]  tries, tries_n;
  tile_t       x_n, y_n;
  logic [9:0]  prev_xy, prev_n;
  logic        p1_n, p2_n;
  logic [15:0] lfsr_q;
  tile_t       cand_x, cand_y, fb_x;
  logic        cand_ok;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .q      (lfsr_q)
  );

  assign cand_x  = lfsr_q[4:0];
  assign cand_y  = lfsr_q[9:5];
  assign cand_ok = (cand_x <= GX) && (cand_y <= GY) && ({cand_x, cand_y} != prev_xy);
  // The centre fallback must still move the gold if it was last shown there
  assign fb_x    = ({FB_X, FB_Y} == prev_xy) ? FB_X + 5'd1 : FB_X;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_HIDDEN;
      frame_cnt <= RESPAWN_LD;
      tries     <= '0;
      randomX   <= '0;
      randomY   <= '0;
      prev_xy   <= '0;
      p1_score  <= 1'b0;
      p2_score  <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      tries     <= tries_n;
      randomX   <= x_n;
      randomY   <= y_n;
      prev_xy   <= prev_n;
      p1_score  <= p1_n;
      p2_score  <= p2_n;
    end
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    tries_n     = tries;
    x_n         = randomX;
    y_n         = randomY;
    prev_n      = prev_xy;
    p1_n        = 1'b0;
    p2_n        = 1'b0;
    gold_up     = 1'b0;
    gold_active = 1'b0;
    case (state)
      S_HIDDEN: begin
        if (frame_tick) begin
          if (frame_cnt <= 16'd1) begin
            frame_cnt_n = '0;
            tries_n     = '0;
            state_n     = S_PICK;
          end else begin
            frame_cnt_n = frame_cnt - 16'd1;
          end
        end
      end
      S_PICK: begin
        if (cand_ok) begin
          x_n     = cand_x;
          y_n     = cand_y;
          state_n = S_SPAWN;
        end else if (tries == LAST_TRY) begin
          x_n     = fb_x;
          y_n     = FB_Y;
          state_n = S_SPAWN;
        end else begin
          tries_n = tries + 4'd1;
        end
      end
      S_SPAWN: begin
        gold_up     = 1'b1;
        prev_n      = {randomX, randomY};
        frame_cnt_n = LIFE_LD;
        state_n     = S_ACTIVE;
      end
      S_ACTIVE: begin
        gold_active = 1'b1;
        // Player 1 has priority when both tanks reach the gold together
        if (gold_take1) begin
          p1_n        = 1'b1;
          frame_cnt_n = RESPAWN_LD;
          state_n     = S_HIDDEN;
        end else if (gold_take2) begin
          p2_n        = 1'b1;
          frame_cnt_n = RESPAWN_LD;
          state_n     = S_HIDDEN;
        end
`ifdef GOLD_TIMEOUT_EN
        else if (frame_tick) begin
          if (frame_cnt <= 16'd1) begin
            frame_cnt_n = RESPAWN_LD;
            state_n     = S_HIDDEN;
          end else begin
            frame_cnt_n = frame_cnt - 16'd1;
          end
        end
`else
        else begin
          frame_cnt_n = frame_cnt;
        end
`endif
      end
      default: state_n = S_HIDDEN;
    endcase
  end

endmodule

// File: tb/tb_gold_spawn_controller.sv
// tb/tb_gold_spawn_controller.sv - directed self-checking bench for gold_spawn_controller
module tb_gold_spawn_controller;

  logic       clk;
  logic       resetN, frame_tick, gold_take1, gold_take2;
  logic [4:0] randomX, randomY;
  logic       gold_up, gold_active, p1_score, p2_score;

  logic       fb_resetN, fb_tick, fb_take1, fb_take2;
  logic [4:0] fb_x, fb_y;
  logic       fb_up, fb_active, fb_p1, fb_p2;

  int checks = 0;
  int errors = 0;
  int ups    = 0;
  logic [4:0] px, py;

  gold_spawn_controller #(
    .RESPAWN_FRAMES  (4),
    .LIFETIME_FRAMES (3)
  ) u_dut (
    .clk         (clk),
    .resetN      (resetN),
    .frame_tick  (frame_tick),
    .gold_take1  (gold_take1),
    .gold_take2  (gold_take2),
    .randomX     (randomX),
    .randomY     (randomY),
    .gold_up     (gold_up),
    .gold_active (gold_active),
    .p1_score    (p1_score),
    .p2_score    (p2_score)
  );

  // Seed 16'hFE00 yields thirteen illegal candidates in a row from reset
  gold_spawn_controller #(
    .RESPAWN_FRAMES (1),
    .LFSR_SEED      (16'hFE00)
  ) u_fb (
    .clk         (clk),
    .resetN      (fb_resetN),
    .frame_tick  (fb_tick),
    .gold_take1  (fb_take1),
    .gold_take2  (fb_take2),
    .randomX     (fb_x),
    .randomY     (fb_y),
    .gold_up     (fb_up),
    .gold_active (fb_active),
    .p1_score    (fb_p1),
    .p2_score    (fb_p2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    ups += int'(gold_up);
    frame_tick = 1'b0;
    @(negedge clk);
    ups += int'(gold_up);
  endtask

  task automatic last_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_up(input string tag);
    int n = 0;
    while (gold_up !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_up_seen"}, gold_up, 1);
    check({tag, "_x_range"}, (randomX <= 5'd19), 1);
    check({tag, "_y_range"}, (randomY <= 5'd14), 1);
  endtask

  initial begin
    int n;
    int p1c, p2c;
    resetN = 1'b0; frame_tick = 1'b0; gold_take1 = 1'b0; gold_take2 = 1'b0;
    fb_resetN = 1'b0; fb_tick = 1'b0; fb_take1 = 1'b0; fb_take2 = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_x", randomX, 0);
    check("rst_y", randomY, 0);
    check("rst_up", gold_up, 0);
    check("rst_active", gold_active, 0);
    check("rst_p1", p1_score, 0);
    check("rst_p2", p2_score, 0);

    resetN = 1'b1;
    fb_resetN = 1'b1;
    fb_tick = 1'b1;
    @(negedge clk);
    fb_tick = 1'b0;
    n = 0;
    while (fb_up !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("t4_fb_latency", n, 8);
    check("t4_fb_up", fb_up, 1);
    check("t4_fb_x", fb_x, 9);
    check("t4_fb_y", fb_y, 7);
    @(negedge clk);
    check("t4_fb_active", fb_active, 1);
    check("t4_fb_up_single", fb_up, 0);
    check("t4_main_idle", gold_active, 0);

    ups = 0;
    repeat (3) tick();
    check("t1_no_early_up", ups, 0);
    last_tick();
    wait_up("t1");
    px = randomX; py = randomY;
    @(negedge clk);
    check("t1_up_single", gold_up, 0);
    check("t1_active", gold_active, 1);

`ifdef GOLD_TIMEOUT_EN
    repeat (2) tick();
    check("t5_active_before_expiry", gold_active, 1);
    last_tick();
    check("t5_expired", gold_active, 0);
    check("t5_expire_p1", p1_score, 0);
    check("t5_expire_p2", p2_score, 0);
    @(negedge clk);
    check("t5_expire_p1_late", p1_score, 0);
    check("t5_expire_p2_late", p2_score, 0);
    repeat (3) tick();
    last_tick();
    wait_up("t5_re");
    @(negedge clk);
    repeat (2) tick();
    frame_tick = 1'b1;
    gold_take1 = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    gold_take1 = 1'b0;
    check("t5_take_wins_p1", p1_score, 1);
    check("t5_take_wins_active", gold_active, 0);
    repeat (3) tick();
    last_tick();
    wait_up("t5_re2");
    px = randomX; py = randomY;
    @(negedge clk);
`else
    repeat (5) tick();
    check("t5_no_expiry", gold_active, 1);
    check("t5_x_stable", randomX, px);
    check("t5_y_stable", randomY, py);
`endif

    p1c = 0; p2c = 0;
    gold_take1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t2_p1_first", p1_score, 1);
        check("t2_active_drop", gold_active, 0);
      end
      p1c += int'(p1_score);
      p2c += int'(p2_score);
    end
    gold_take1 = 1'b0;
    @(negedge clk);
    p1c += int'(p1_score);
    check("t2_p1_count", p1c, 1);
    check("t2_p2_count", p2c, 0);
    check("t2_inactive", gold_active, 0);
    ups = 0;
    repeat (3) tick();
    check("t2_no_up_3_ticks", ups, 0);
    last_tick();
    wait_up("t2_re");
    check("t2_new_pos", ({randomX, randomY} !== {px, py}), 1);
    @(negedge clk);

    gold_take1 = 1'b1;
    gold_take2 = 1'b1;
    @(negedge clk);
    gold_take1 = 1'b0;
    gold_take2 = 1'b0;
    check("t3_p1", p1_score, 1);
    check("t3_p2", p2_score, 0);
    check("t3_inactive", gold_active, 0);
    @(negedge clk);
    check("t3_p1_done", p1_score, 0);
    check("t3_p2_quiet", p2_score, 0);

    repeat (3) tick();
    last_tick();
    wait_up("t6a_spawn");
    @(negedge clk);
    check("t6a_active", gold_active, 1);
    resetN = 1'b0;
    #1;
    check("t6a_rst_x", randomX, 0);
    check("t6a_rst_y", randomY, 0);
    check("t6a_rst_active", gold_active, 0);
    check("t6a_rst_up", gold_up, 0);
    check("t6a_rst_p", {p1_score, p2_score}, 0);
    @(negedge clk);
    resetN = 1'b1;
    ups = 0;
    repeat (3) tick();
    check("t6a_restart_no_up", ups, 0);
    check("t6a_restart_inactive", gold_active, 0);
    last_tick();
    wait_up("t6a_re");
    @(negedge clk);

    gold_take1 = 1'b1;
    @(negedge clk);
    gold_take1 = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    last_tick();
    check("t6b_in_pick_no_up", gold_up, 0);
    resetN = 1'b0;
    #1;
    check("t6b_rst_x", randomX, 0);
    check("t6b_rst_y", randomY, 0);
    check("t6b_rst_up", gold_up, 0);
    check("t6b_rst_active", gold_active, 0);
    @(negedge clk);
    resetN = 1'b1;
    ups = 0;
    repeat (3) tick();
    check("t6b_restart_no_up", ups, 0);
    check("t6b_restart_inactive", gold_active, 0);
    last_tick();
    wait_up("t6b_re");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
